// File: rtl/scan_disp_pkg.sv
// -----------------------------------------------------------------------------
// scan_disp_pkg
// Shared definitions for the 74HC595 scanning seven-segment display driver:
//   - segment patterns (bit6..0 = gfedcba) for digits 0-9, blank and dash
//   - seg_encode(): BCD nibble + dp + blank flag -> segment byte (bit7 = dp)
//   - frame_width(): bits in one {sel, seg} frame for a given digit count
//   - shift_state_t: states of the serialiser FSM
// -----------------------------------------------------------------------------
package scan_disp_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } shift_state_t;

   // One frame carries one select bit per digit followed by the 8 segment bits.
   function automatic int frame_width(input int digits);
      return digits + 8;
   endfunction

   // Active-high segment byte. Non-decimal nibbles render blank.
   function automatic logic [7:0] seg_encode(input logic [3:0] nibble,
                                             input logic       dp,
                                             input logic       blank);
      logic [6:0] pat;
      if (blank) begin
         pat = SEG_BLANK;
      end else begin
         case (nibble)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
         endcase
      end
      return {dp, pat};
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Iterative double-dabble binary-to-BCD converter: one add-3/shift step per
// clock, DATA_W steps per conversion. The internal BCD register is wider than
// DIGITS so values that do not fit on the display raise o_overflow.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_start        accepted when idle; i_data is captured on that edge
//   i_data         unsigned value to convert
//   o_busy         conversion in progress
//   o_done         one-cycle pulse after the final step; results valid from here
//   o_bcd          DIGITS BCD nibbles, nibble 0 = units
//   o_overflow     value needs more than DIGITS decimal digits
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
   parameter int DATA_W = 20,
   parameter int DIGITS = 6
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [DATA_W-1:0]     i_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_overflow
);

   // Every decimal digit absorbs more than 3 bits, so this always holds the
   // full value; at least one nibble above DIGITS keeps the overflow slice legal.
   localparam int BCD_RAW = (DATA_W + 2) / 3 + 1;
   localparam int BCD_N   = (BCD_RAW > DIGITS) ? BCD_RAW : DIGITS + 1;
   localparam int CNT_W   = $clog2(DATA_W + 1);

   logic [DATA_W-1:0]  r_bin;
   logic [4*BCD_N-1:0] r_bcd;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic               r_done;

   logic [4*BCD_N-1:0] w_adj;
   logic [4*BCD_N-1:0] w_bcd_nxt;

   always_comb begin
      // NOTE: give every comb output a value before any condition so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      w_adj = r_bcd;
      for (int i = 0; i < BCD_N; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) begin
            w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         end
      end
      w_bcd_nxt = {w_adj[4*BCD_N-2:0], r_bin[DATA_W-1]};
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values
   // regardless of statement order.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_bin  <= '0;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start && !r_busy) begin
            r_bin  <= i_data;
            r_bcd  <= '0;
            r_cnt  <= CNT_W'(DATA_W);
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_bcd <= w_bcd_nxt;
            r_bin <= r_bin << 1;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_bcd      = r_bcd[4*DIGITS-1:0];
   assign o_overflow = |r_bcd[4*BCD_N-1:4*DIGITS];

endmodule

// File: rtl/scan_display_595_gen.sv
// -----------------------------------------------------------------------------
// scan_display_595_gen
// Scanning seven-segment driver for a chain of 74HC595s. A value accepted on
// the valid/ready handshake is converted to BCD, formatted (leading-zero
// blanking, minus sign, decimal points, overflow dashes) into a display
// register, then each digit slot shifts one {sel, seg} frame MSB first onto
// ds/shcp and latches it with stcp. oe is PWM-dimmed by brightness.
// Ports:
//   sys_clk, sys_rst      clock, asynchronous active-high reset
//   data_in, data_valid   value and qualifier (also qualifies sign/dp_mask/blank_lz)
//   data_ready            converter idle
//   sign                  show '-' left of the most significant digit
//   dp_mask               decimal point per digit, bit 0 = rightmost
//   blank_lz              leading-zero blanking enable
//   brightness            0 = off .. 15 = full on
//   ds, shcp, stcp, oe    595 serial data, shift clock, latch, output enable (low)
// -----------------------------------------------------------------------------
module scan_display_595_gen
   import scan_disp_pkg::*;
#(
   parameter int DIGITS         = 6,
   parameter int DATA_W         = 20,
   parameter int SCAN_DIV       = 50000,
   parameter int SHIFT_DIV      = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit SEL_ACTIVE_LOW = 1'b1
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic              sign,
   input  logic [DIGITS-1:0] dp_mask,
   input  logic              blank_lz,
   input  logic [3:0]        brightness,
   output logic              ds,
   output logic              shcp,
   output logic              stcp,
   output logic              oe
);

   localparam int FRAME_W = frame_width(DIGITS);
   localparam int IDX_W   = $clog2(DIGITS);
   localparam int SLOT_W  = $clog2(SCAN_DIV);
   localparam int DIV_W   = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
   localparam int BIT_W   = $clog2(FRAME_W + 1);

   // A whole frame plus latch must fit inside one digit slot.
   if (SCAN_DIV < 2 * SHIFT_DIV * (FRAME_W + 1) + 2) begin : g_scan_div_check
      $error("SCAN_DIV too small for one frame shift and latch");
   end
   if (DIGITS < 2 || DIGITS > 8) begin : g_digits_check
      $error("DIGITS must be in 2..8");
   end

   // ---------------------------------------------------------------- input side
   logic                r_busy;
   logic                r_sign;
   logic                r_blank;
   logic [DIGITS-1:0]   r_dp;
   logic [7:0]          r_disp [DIGITS];

   logic                w_accept;
   logic                w_conv_busy;
   logic                w_conv_done;
   logic                w_bcd_ovf;
   logic [4*DIGITS-1:0] w_bcd;

   assign w_accept   = data_valid && !r_busy && !w_conv_busy;
   assign data_ready = !r_busy;

   bin2bcd_seq #(
      .DATA_W (DATA_W),
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .i_clk      (sys_clk),
      .i_rst      (sys_rst),
      .i_start    (w_accept),
      .i_data     (data_in),
      .o_busy     (w_conv_busy),
      .o_done     (w_conv_done),
      .o_bcd      (w_bcd),
      .o_overflow (w_bcd_ovf)
   );

   // ---------------------------------------------------------------- formatting
   int         w_msd;
   logic       w_ovf;
   logic [7:0] w_fmt [DIGITS];

   always_comb begin
      // Highest non-zero digit; digit 0 counts as significant even when zero.
      w_msd = 0;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_bcd[4*i +: 4] != 4'd0) begin
            w_msd = i;
         end
      end
      // The sign needs the position just above the value.
      w_ovf = w_bcd_ovf || (r_sign && (w_msd == DIGITS - 1));
      for (int i = 0; i < DIGITS; i++) begin
         if (w_ovf) begin
            w_fmt[i] = {1'b0, SEG_DASH};
         end else if (r_sign && (i == w_msd + 1)) begin
            w_fmt[i] = {r_dp[i], SEG_DASH};
         end else begin
            w_fmt[i] = seg_encode(w_bcd[4*i +: 4], r_dp[i], r_blank && (i > w_msd));
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_busy  <= 1'b0;
         r_sign  <= 1'b0;
         r_blank <= 1'b0;
         r_dp    <= '0;
         // NOTE: this small register file is reset on purpose so the display
         // starts blank; larger RAM-style arrays would normally be left unreset.
         for (int i = 0; i < DIGITS; i++) begin
            r_disp[i] <= 8'h00;
         end
      end else begin
         if (w_accept) begin
            r_busy  <= 1'b1;
            r_sign  <= sign;
            r_blank <= blank_lz;
            r_dp    <= dp_mask;
         end else if (w_conv_done) begin
            // All digits change together so a scan never mixes two values.
            r_busy <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
               r_disp[i] <= w_fmt[i];
            end
         end
      end
   end

   // ---------------------------------------------------------------- scan timing
   logic [SLOT_W-1:0] r_slot;
   logic [IDX_W-1:0]  r_digit_idx;
   logic [IDX_W-1:0]  r_req_idx;
   logic              r_pending;
   logic              w_tick;
   logic              w_load;

   assign w_tick = (r_slot == SLOT_W'(SCAN_DIV - 1));

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_slot      <= '0;
         r_digit_idx <= '0;
         r_req_idx   <= '0;
         r_pending   <= 1'b0;
      end else begin
         r_slot <= w_tick ? '0 : r_slot + 1'b1;
         if (w_tick) begin
            // The requested frame shows the current digit; the index then moves
            // on, so the first frame after reset is digit 0.
            r_pending   <= 1'b1;
            r_req_idx   <= r_digit_idx;
            r_digit_idx <= (r_digit_idx == IDX_W'(DIGITS - 1)) ? '0 : r_digit_idx + 1'b1;
         end else if (w_load) begin
            r_pending <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------- frame build
   logic [DIGITS-1:0]  w_sel;
   logic [7:0]         w_seg;
   logic [FRAME_W-1:0] w_frame;

   always_comb begin
      w_sel = DIGITS'(1) << r_req_idx;
      if (SEL_ACTIVE_LOW) begin
         w_sel = ~w_sel;
      end
      w_seg = r_disp[r_req_idx];
      if (SEG_ACTIVE_LOW) begin
         w_seg = ~w_seg;
      end
      w_frame = {w_sel, w_seg};
   end

   // ---------------------------------------------------------------- shift FSM
   shift_state_t       r_state, w_state_nxt;
   logic [FRAME_W-1:0] r_shreg, w_shreg_nxt;
   logic [DIV_W-1:0]   r_div,   w_div_nxt;
   logic [BIT_W-1:0]   r_bits,  w_bits_nxt;
   logic               r_ds,    w_ds_nxt;
   logic               r_shcp,  w_shcp_nxt;
   logic               r_stcp,  w_stcp_nxt;
   logic               w_div_last;

   assign w_div_last = (r_div == DIV_W'(SHIFT_DIV - 1));

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state <= ST_IDLE;
         r_shreg <= '0;
         r_div   <= '0;
         r_bits  <= '0;
         r_ds    <= 1'b0;
         r_shcp  <= 1'b0;
         r_stcp  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_shreg <= w_shreg_nxt;
         r_div   <= w_div_nxt;
         r_bits  <= w_bits_nxt;
         r_ds    <= w_ds_nxt;
         r_shcp  <= w_shcp_nxt;
         r_stcp  <= w_stcp_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_div_nxt   = r_div;
      w_bits_nxt  = r_bits;
      w_ds_nxt    = r_ds;
      w_shcp_nxt  = r_shcp;
      w_stcp_nxt  = r_stcp;
      w_load      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_shcp_nxt = 1'b0;
            w_stcp_nxt = 1'b0;
            if (r_pending) begin
               w_load      = 1'b1;
               w_shreg_nxt = w_frame;
               w_ds_nxt    = w_frame[FRAME_W-1];
               w_div_nxt   = '0;
               w_bits_nxt  = '0;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!w_div_last) begin
               w_div_nxt = r_div + 1'b1;
            end else begin
               w_div_nxt = '0;
               if (!r_shcp) begin
                  w_shcp_nxt = 1'b1;
                  w_bits_nxt = r_bits + 1'b1;
               end else begin
                  // ds only moves on the falling edge, so it is settled for a
                  // full low phase before the next rising edge.
                  w_shcp_nxt = 1'b0;
                  if (r_bits == BIT_W'(FRAME_W)) begin
                     w_stcp_nxt  = 1'b1;
                     w_state_nxt = ST_LATCH;
                  end else begin
                     w_shreg_nxt = r_shreg << 1;
                     w_ds_nxt    = r_shreg[FRAME_W-2];
                  end
               end
            end
         end
         ST_LATCH: begin
            if (!w_div_last) begin
               w_div_nxt = r_div + 1'b1;
            end else begin
               w_div_nxt   = '0;
               w_stcp_nxt  = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign ds   = r_ds;
   assign shcp = r_shcp;
   assign stcp = r_stcp;

   // ---------------------------------------------------------------- dimming
   logic [3:0] r_pwm;
   logic       r_oe;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_pwm <= '0;
         r_oe  <= 1'b1;
      end else begin
         r_pwm <= (r_pwm == 4'd14) ? 4'd0 : r_pwm + 1'b1;
         // 15 PWM phases: brightness=15 is full on, 0 is never on.
         r_oe  <= (brightness == 4'd15) ? 1'b0 : !(r_pwm < brightness);
      end
   end

   assign oe = r_oe;

endmodule
